// File: rtl/encod_load_pkg.sv
// Shared seven-segment constants and the output-buffer entry type for the
// segment encoder and the 3-bit-to-segment decoder.
package encod_load_pkg;

  localparam int unsigned SEG_W        = 7;
  localparam int unsigned CODE_W       = 3;
  localparam int unsigned CNT_W        = 4;
  localparam int unsigned STABLE_N_DEF = 3;

  // Active-low patterns, bit6=a .. bit0=g
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;

  typedef struct packed {
    logic              err;
    logic [CODE_W-1:0] code;
  } codeEntry_t;

  function automatic logic [SEG_W-1:0] codeToSeg(input logic [CODE_W-1:0] code);
    logic [SEG_W-1:0] seg;
    case (code)
      CODE_W'(0): seg = SEG_0;
      CODE_W'(1): seg = SEG_1;
      CODE_W'(2): seg = SEG_2;
      CODE_W'(3): seg = SEG_3;
      CODE_W'(4): seg = SEG_4;
      CODE_W'(5): seg = SEG_5;
      CODE_W'(6): seg = SEG_6;
      default:    seg = SEG_7;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/encod_load_seg_to_code.sv
// Pure lookup from an active-low segment pattern to its digit code.
module seg_to_code
  import encod_load_pkg::*;
(
  input  logic [SEG_W-1:0]  seg,
  output logic [CODE_W-1:0] code,
  output logic              illegal
);

  always_comb begin
    code    = '0;
    illegal = 1'b0;
    case (seg)
      SEG_0:   code = CODE_W'(0);
      SEG_1:   code = CODE_W'(1);
      SEG_2:   code = CODE_W'(2);
      SEG_3:   code = CODE_W'(3);
      SEG_4:   code = CODE_W'(4);
      SEG_5:   code = CODE_W'(5);
      SEG_6:   code = CODE_W'(6);
      SEG_7:   code = CODE_W'(7);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/encod_load.sv
// Debounces accepted segment patterns, encodes qualified ones to a 3-bit code
// and queues them in a 2-entry head/tail buffer with an illegal-pattern counter.
module encod_load
  import encod_load_pkg::*;
#(
  parameter int unsigned STABLE_N = STABLE_N_DEF,
  parameter int unsigned ERR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEG_W-1:0]  seg_i,
  input  logic              seg_valid_i,
  output logic              seg_ready_o,
  output logic [CODE_W-1:0] code_o,
  output logic              code_err_o,
  output logic              code_valid_o,
  input  logic              code_ready_i,
  output logic [ERR_W-1:0]  err_cnt_o,
  input  logic              clr_err_i
);

  logic [SEG_W-1:0]  lastSeg;
  logic [CNT_W-1:0]  stableCnt;
  codeEntry_t        headQ;
  codeEntry_t        tailQ;
  logic              headValid;
  logic              tailValid;
  logic [ERR_W-1:0]  errCnt;

  logic [CODE_W-1:0] lutCode;
  logic              lutIllegal;
  logic              accept;
  logic              pop;
  logic              push;
  codeEntry_t        newEntry;

  seg_to_code uLut (
    .seg     (seg_i),
    .code    (lutCode),
    .illegal (lutIllegal)
  );

  // Buffer is full exactly when the tail slot is occupied.
  assign seg_ready_o  = ~tailValid;
  assign accept       = seg_valid_i & ~tailValid;
  assign pop          = headValid & code_ready_i;
  assign code_valid_o = headValid;
  assign code_o       = headQ.code;
  assign code_err_o   = headQ.err;
  assign err_cnt_o    = errCnt;

  // Push on the accept that brings the run length up to STABLE_N.
  always_comb begin
    push          = 1'b0;
    newEntry.err  = lutIllegal;
    newEntry.code = lutIllegal ? '0 : lutCode;
    if (accept) begin
      if (seg_i == lastSeg) begin
        push = (stableCnt == CNT_W'(STABLE_N - 1));
      end else begin
        push = (STABLE_N == 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastSeg   <= SEG_BLANK;
      stableCnt <= '0;
    end else if (accept) begin
      if (seg_i == lastSeg) begin
        if (stableCnt < CNT_W'(STABLE_N)) begin
          stableCnt <= stableCnt + CNT_W'(1);
        end
      end else begin
        lastSeg   <= seg_i;
        stableCnt <= CNT_W'(1);
      end
    end
  end

  // A push never coincides with a pop while the tail is occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headQ     <= '0;
      tailQ     <= '0;
      headValid <= 1'b0;
      tailValid <= 1'b0;
    end else if (pop) begin
      if (tailValid) begin
        headQ     <= tailQ;
        tailValid <= 1'b0;
      end else if (push) begin
        headQ     <= newEntry;
      end else begin
        headValid <= 1'b0;
      end
    end else if (push) begin
      if (!headValid) begin
        headQ     <= newEntry;
        headValid <= 1'b1;
      end else begin
        tailQ     <= newEntry;
        tailValid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errCnt <= '0;
    end else if (clr_err_i) begin
      errCnt <= '0;
    end else if (push && lutIllegal && (errCnt != '1)) begin
      errCnt <= errCnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_encod_load.sv
// Randomised and directed checks of encod_load against a queue-based model;
// two instances run side by side (default parameters, and STABLE_N=1/ERR_W=2).
module tb_encod_load;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_i = 7'h7f;
  logic       seg_valid_i = 1'b0;
  logic       code_ready_i = 1'b1;
  logic       clr_err_i = 1'b0;

  logic       rdy [2];
  logic       vld [2];
  logic [2:0] code [2];
  logic       err [2];
  logic [7:0] errc [2];
  logic [7:0] errc0;
  logic [1:0] errc1;

  int nTests = 0;
  int nFail  = 0;
  bit started = 1'b0;

  logic [6:0] tab [8] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};
  logic [6:0] ill [3] = '{7'b1111111, 7'b1111110, 7'b0000000};
  int         sn [2]     = '{3, 1};
  int         errMax [2] = '{255, 3};

  always #5 clk = ~clk;

  encod_load dut0 (
    .clk(clk), .rst_n(rst_n), .seg_i(seg_i), .seg_valid_i(seg_valid_i),
    .seg_ready_o(rdy[0]), .code_o(code[0]), .code_err_o(err[0]),
    .code_valid_o(vld[0]), .code_ready_i(code_ready_i),
    .err_cnt_o(errc0), .clr_err_i(clr_err_i)
  );

  encod_load #(.STABLE_N(1), .ERR_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .seg_i(seg_i), .seg_valid_i(seg_valid_i),
    .seg_ready_o(rdy[1]), .code_o(code[1]), .code_err_o(err[1]),
    .code_valid_o(vld[1]), .code_ready_i(code_ready_i),
    .err_cnt_o(errc1), .clr_err_i(clr_err_i)
  );

  assign errc[0] = errc0;
  assign errc[1] = {6'b0, errc1};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void lookup(input logic [6:0] s, output logic [2:0] c, output bit e);
    c = 3'd0;
    e = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (tab[i] == s) begin
        c = 3'(i);
        e = 1'b0;
      end
    end
  endfunction

  // Behavioural model: run length of the last accepted pattern, a queue buffer.
  logic [6:0] mLast [2];
  int         mCnt [2];
  logic [3:0] mQ [2][$];
  int         mErr [2];

  always @(posedge clk or negedge rst_n) begin
    bit acc, pp, ps, e;
    logic [2:0] c;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mLast[k] = 7'h7f;
        mCnt[k]  = 0;
        mQ[k].delete();
        mErr[k]  = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        acc = seg_valid_i && (mQ[k].size() < 2);
        pp  = (mQ[k].size() > 0) && code_ready_i;
        ps  = 1'b0;
        if (acc) begin
          if (seg_i == mLast[k]) begin
            if (mCnt[k] < sn[k]) begin
              mCnt[k]++;
              ps = (mCnt[k] == sn[k]);
            end
          end else begin
            mLast[k] = seg_i;
            mCnt[k]  = 1;
            ps = (sn[k] == 1);
          end
        end
        lookup(seg_i, c, e);
        if (pp) void'(mQ[k].pop_front());
        if (ps) mQ[k].push_back({e, c});
        if (clr_err_i) mErr[k] = 0;
        else if (ps && e && (mErr[k] < errMax[k])) mErr[k]++;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("ready%0d", k), 32'(rdy[k]), 32'(mQ[k].size() < 2));
        check($sformatf("valid%0d", k), 32'(vld[k]), 32'(mQ[k].size() > 0));
        check($sformatf("errcnt%0d", k), 32'(errc[k]), 32'(mErr[k]));
        if (mQ[k].size() > 0) begin
          check($sformatf("entry%0d", k), {28'b0, err[k], code[k]}, 32'(mQ[k][0]));
        end
      end
    end
  end

  // Entries popped from the default instance, for order checks.
  logic [3:0] popLog [$];
  always @(posedge clk) begin
    if (rst_n && vld[0] && code_ready_i) popLog.push_back({err[0], code[0]});
  end

  task automatic checkLog(input string name, input logic [3:0] exp [$]);
    check({name, "_len"}, 32'(popLog.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < popLog.size(); i++) begin
      check($sformatf("%s_%0d", name, i), 32'(popLog[i]), 32'(exp[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pattern until it has been accepted n times by the default instance.
  task automatic sendSeg(input logic [6:0] s, input int n);
    bit ok;
    int w;
    for (int i = 0; i < n; i++) begin
      ok = 1'b0;
      w  = 0;
      seg_i = s;
      seg_valid_i = 1'b1;
      while (!ok && w < 50) begin
        @(negedge clk);
        ok = rdy[0];
        tick();
        w++;
      end
      if (!ok) check("accept_timeout", 32'(0), 32'(1));
    end
    seg_valid_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp [$];
    logic [6:0] cur;
    int hold, p;
    bit rstPend;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(vld[0]), 32'(0));
    check("rst_code", 32'(code[0]), 32'(0));
    check("rst_err", 32'(err[0]), 32'(0));
    check("rst_errcnt", 32'(errc[0]), 32'(0));
    rst_n = 1'b1;
    started = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(rdy[0]), 32'(1));
    tick();

    // Each legal digit three times: one output each, one cycle after the third accept.
    popLog.delete();
    for (int d = 0; d < 8; d++) begin
      sendSeg(tab[d], 3);
      @(negedge clk);
      check("lat_valid", 32'(vld[0]), 32'(1));
      check("lat_code", {28'b0, err[0], code[0]}, 32'(d));
      tick();
    end
    repeat (3) tick();
    exp = {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
    checkLog("digits", exp);

    // Short run of 1 followed by a full run of 0.
    popLog.delete();
    sendSeg(tab[1], 2);
    sendSeg(tab[0], 3);
    repeat (3) tick();
    exp = {4'h0};
    checkLog("short_run", exp);

    // Illegal blank twice around a legal digit.
    popLog.delete();
    sendSeg(7'b1111111, 3);
    sendSeg(tab[1], 3);
    sendSeg(7'b1111111, 3);
    repeat (3) tick();
    exp = {4'h8, 4'h1, 4'h8};
    checkLog("illegal", exp);
    check("errcnt_two", 32'(errc[0]), 32'(2));
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    @(negedge clk);
    check("errcnt_clr", 32'(errc[0]), 32'(0));
    tick();

    // Backpressure: two entries fill the buffer, head held, then drain in order.
    popLog.delete();
    code_ready_i = 1'b0;
    sendSeg(tab[2], 3);
    sendSeg(tab[5], 3);
    seg_i = tab[7];
    seg_valid_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_ready", 32'(rdy[0]), 32'(0));
      check("bp_valid", 32'(vld[0]), 32'(1));
      check("bp_code", 32'(code[0]), 32'(2));
      tick();
    end
    code_ready_i = 1'b1;
    sendSeg(tab[7], 3);
    repeat (3) tick();
    exp = {4'h2, 4'h5, 4'h7};
    checkLog("drain", exp);

    // Saturation of the narrow counter: five illegal changes on the STABLE_N=1 instance.
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    for (int i = 0; i < 5; i++) sendSeg((i % 2 == 0) ? 7'b1111110 : 7'b1111101, 1);
    repeat (2) tick();
    check("sat_errcnt_w2", 32'(errc[1]), 32'(3));
    check("sat_errcnt_w8", 32'(errc[0]), 32'(0));

    // Asynchronous reset mid-qualification with one entry buffered.
    code_ready_i = 1'b0;
    sendSeg(tab[3], 3);
    sendSeg(tab[4], 2);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(vld[0]), 32'(0));
    check("arst_code", 32'(code[0]), 32'(0));
    check("arst_errcnt", 32'(errc[0]), 32'(0));
    check("arst_ready", 32'(rdy[0]), 32'(1));
    check("arst_valid_n1", 32'(vld[1]), 32'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    code_ready_i = 1'b1;
    popLog.delete();
    sendSeg(tab[4], 2);
    repeat (2) tick();
    @(negedge clk);
    check("arst_requal_none", 32'(vld[0]), 32'(0));
    tick();
    sendSeg(tab[4], 1);
    @(negedge clk);
    check("arst_requal_valid", 32'(vld[0]), 32'(1));
    check("arst_requal_code", 32'(code[0]), 32'(4));
    tick();

    // Random traffic with occasional clears and resets.
    hold = 0;
    rstPend = 1'b0;
    cur = tab[0];
    for (int c = 0; c < 3000; c++) begin
      if (rstPend) begin
        rst_n = 1'b1;
        rstPend = 1'b0;
      end
      if (hold == 0) begin
        p = int'($urandom_range(0, 10));
        cur = (p < 8) ? tab[p] : ill[p - 8];
        hold = int'($urandom_range(1, 6));
      end
      hold--;
      seg_i = cur;
      seg_valid_i = ($urandom_range(0, 3) != 0);
      code_ready_i = ($urandom_range(0, 3) != 0);
      clr_err_i = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        rstPend = 1'b1;
      end
      tick();
    end
    rst_n = 1'b1;
    seg_valid_i = 1'b0;
    clr_err_i = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
